// File: rtl/fft_stage_sequencer.sv
// Radix-2 in-place DIT FFT sequencer: walks stages/butterflies, feeds one shared
// pipelined butterfly and issues write-back. Define FFT_SEQ_INVERSE_EN to add inv_i.

module fft_stage_sequencer #(
  parameter int N_LOG2     = 4,
  parameter int FRAC_BITS  = 15,
  parameter int BF_LATENCY = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic                      start_i,
`ifdef FFT_SEQ_INVERSE_EN
  input  logic                      inv_i,
`endif
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      rd_en_o,
  output logic [N_LOG2-1:0]         rd_addr_a_o,
  output logic [N_LOG2-1:0]         rd_addr_b_o,
  output logic                      bf_valid_o,
  output logic [FRAC_BITS:0]        twid_o,
  output logic                      wr_en_o,
  output logic [N_LOG2-1:0]         wr_addr_a_o,
  output logic [N_LOG2-1:0]         wr_addr_b_o,
  output logic [$clog2(N_LOG2):0]   stage_o
);

  localparam int KW     = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
  localparam int SW     = $clog2(N_LOG2) + 1;
  localparam int TW     = FRAC_BITS + 1;
  localparam int TSH    = FRAC_BITS - N_LOG2 + 1;
  localparam int AW     = 2 * N_LOG2;
  localparam int K_LAST = (1 << (N_LOG2 - 1)) - 1;
  localparam int S_LAST = N_LOG2 - 1;
  localparam logic [BF_LATENCY:0] LAST_ONLY = (BF_LATENCY+1)'(1) << BF_LATENCY;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                      state;
  logic [KW-1:0]               k_q;
  logic                        inv_q;
  logic [BF_LATENCY:0]         vld_pipe;
  logic [BF_LATENCY:0][AW-1:0] addr_pipe;
  logic                        drain_done;
  logic [KW-1:0]               k_nxt;
  logic [SW-1:0]               s_nxt;

  // a = k with a zero inserted at bit s; b = a + 2**s
  function automatic logic [AW-1:0] bf_addr(input logic [SW-1:0] s, input logic [KW-1:0] k);
    logic [N_LOG2-1:0] kk, lo, span, a;
    span = N_LOG2'(1) << s;
    lo   = span - N_LOG2'(1);
    kk   = N_LOG2'(k);
    a    = ((kk & ~lo) << 1) | (kk & lo);
    return {a, a | span};
  endfunction

  function automatic logic [TW-1:0] twid_of(input logic [SW-1:0] s, input logic [KW-1:0] k,
                                            input logic inv);
    logic [N_LOG2-1:0] lo;
    logic [SW-1:0]     sh;
    logic [TW-1:0]     mag;
    lo  = (N_LOG2'(1) << s) - N_LOG2'(1);
    sh  = SW'(S_LAST) - s;
    mag = TW'(N_LOG2'(k) & lo) << sh;
    mag = mag << TSH;
    return inv ? mag : -mag;
  endfunction

  assign k_nxt = k_q + KW'(1);
  assign s_nxt = stage_o + SW'(1);

  // Stage is fully written back when only the oldest slot still holds an op.
  assign drain_done = (vld_pipe == LAST_ONLY);

`ifndef FFT_SEQ_INVERSE_EN
  assign inv_q = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k_q         <= '0;
      stage_o     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
`ifdef FFT_SEQ_INVERSE_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state                      <= ISSUE;
          busy_o                     <= 1'b1;
          rd_en_o                    <= 1'b1;
          k_q                        <= '0;
          stage_o                    <= '0;
          {rd_addr_a_o, rd_addr_b_o} <= bf_addr('0, '0);
`ifdef FFT_SEQ_INVERSE_EN
          inv_q                      <= inv_i;
`endif
        end
        ISSUE: begin
          if (k_q == KW'(K_LAST)) begin
            state   <= DRAIN;
            rd_en_o <= 1'b0;
          end else begin
            k_q                        <= k_nxt;
            {rd_addr_a_o, rd_addr_b_o} <= bf_addr(stage_o, k_nxt);
          end
        end
        DRAIN: if (drain_done) begin
          if (stage_o == SW'(S_LAST)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            state                      <= ISSUE;
            rd_en_o                    <= 1'b1;
            k_q                        <= '0;
            stage_o                    <= s_nxt;
            {rd_addr_a_o, rd_addr_b_o} <= bf_addr(s_nxt, '0);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Twiddle follows the read by one cycle, matching the RAM's sync read.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)       twid_o <= '0;
    else if (rd_en_o) twid_o <= twid_of(stage_o, k_q, inv_q);
  end

  // In-flight ops; address slots only advance with a valid op so the
  // write-address outputs hold between strobes.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en_o;
      if (rd_en_o) addr_pipe[0] <= {rd_addr_a_o, rd_addr_b_o};
      for (int i = 1; i <= BF_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign bf_valid_o                 = vld_pipe[0];
  assign wr_en_o                    = vld_pipe[BF_LATENCY];
  assign {wr_addr_a_o, wr_addr_b_o} = addr_pipe[BF_LATENCY];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer (N_LOG2=4, FRAC_BITS=15, BF_LATENCY=16).

module tb_fft_stage_sequencer;

  localparam int N_LOG2     = 4;
  localparam int FRAC_BITS  = 15;
  localparam int BF_LATENCY = 16;
  localparam int NB         = 8;
  localparam int PERIOD     = NB + BF_LATENCY + 1;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        inv_i = 1'b0;
  logic        busy_o, done_o, rd_en_o, bf_valid_o, wr_en_o;
  logic [3:0]  rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
  logic [15:0] twid_o;
  logic [2:0]  stage_o;

  fft_stage_sequencer #(.N_LOG2(N_LOG2), .FRAC_BITS(FRAC_BITS), .BF_LATENCY(BF_LATENCY)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .start_i     (start_i),
`ifdef FFT_SEQ_INVERSE_EN
    .inv_i       (inv_i),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .bf_valid_o  (bf_valid_o),
    .twid_o      (twid_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o),
    .stage_o     (stage_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int cyc;
    int s;
    int k;
    int a;
    int b;
    int tw;
    bit inv;
  } exp_t;

  exp_t rd_q[$];
  exp_t tw_q[$];
  exp_t wr_q[$];
  int   done_q[$];

  int cyc = 0;
  int base = 0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (rel cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  // Expected frame from the addressing rules: rd at 1+25*s+k, twid one later,
  // write 17 later. Anything at or after abort_rel is killed by reset.
  task automatic push_frame(input bit inv, input int abort_rel);
    exp_t e;
    int   span, j, mag;
    for (int s = 0; s < N_LOG2; s++) begin
      for (int k = 0; k < NB; k++) begin
        span  = 1 << s;
        j     = k % span;
        mag   = (j << (N_LOG2 - 1 - s)) << (FRAC_BITS - N_LOG2 + 1);
        e.s   = s;
        e.k   = k;
        e.a   = (k / span) * 2 * span + j;
        e.b   = e.a + span;
        e.tw  = inv ? mag : ((-mag) & 32'hFFFF);
        e.inv = inv;
        e.cyc = 1 + PERIOD * s + k;
        if (e.cyc < abort_rel) rd_q.push_back(e);
        e.cyc = 2 + PERIOD * s + k;
        if (e.cyc < abort_rel) tw_q.push_back(e);
        e.cyc = 2 + BF_LATENCY + PERIOD * s + k;
        if (e.cyc < abort_rel) wr_q.push_back(e);
      end
    end
    if (abort_rel > 101) done_q.push_back(101);
  endtask

  always @(negedge clk_i) begin : mon
    exp_t e;
    int   d;
    if (rd_en_o) begin
      if (rd_q.size() == 0) check("rd_unexpected", rd_en_o, 0);
      else begin
        e = rd_q.pop_front();
        check("rd_cycle", cyc - base, e.cyc);
        check("rd_addr_a", rd_addr_a_o, e.a);
        check("rd_addr_b", rd_addr_b_o, e.b);
        check("stage", stage_o, e.s);
        if (e.s == 0 && e.k == 0) begin
          check("spot_s0k0_a", rd_addr_a_o, 0);
          check("spot_s0k0_b", rd_addr_b_o, 1);
        end
        if (e.s == 1 && e.k == 1) begin
          check("spot_s1k1_a", rd_addr_a_o, 1);
          check("spot_s1k1_b", rd_addr_b_o, 3);
        end
        if (e.s == 3 && e.k == 7) begin
          check("spot_s3k7_a", rd_addr_a_o, 7);
          check("spot_s3k7_b", rd_addr_b_o, 15);
        end
      end
    end
    if (bf_valid_o) begin
      if (tw_q.size() == 0) check("bf_valid_unexpected", bf_valid_o, 0);
      else begin
        e = tw_q.pop_front();
        check("twid_cycle", cyc - base, e.cyc);
        check("twid", twid_o, e.tw);
        if (e.s == 0 && e.k == 0) check("spot_s0k0_twid", twid_o, 16'h0000);
        if (e.s == 1 && e.k == 1) check("spot_s1k1_twid", twid_o, e.inv ? 16'h4000 : 16'hC000);
        if (e.s == 3 && e.k == 7) check("spot_s3k7_twid", twid_o, e.inv ? 16'h7000 : 16'h9000);
      end
    end
    if (wr_en_o) begin
      if (wr_q.size() == 0) check("wr_unexpected", wr_en_o, 0);
      else begin
        e = wr_q.pop_front();
        check("wr_cycle", cyc - base, e.cyc);
        check("wr_addr_a", wr_addr_a_o, e.a);
        check("wr_addr_b", wr_addr_b_o, e.b);
      end
    end
    if (done_o) begin
      if (done_q.size() == 0) check("done_unexpected", done_o, 0);
      else begin
        d = done_q.pop_front();
        check("done_cycle", cyc - base, d);
      end
    end
  end

  task automatic check_quiet(input string name);
    logic any;
    any = |{busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, bf_valid_o, twid_o,
            wr_en_o, wr_addr_a_o, wr_addr_b_o, stage_o};
    check(name, any, 0);
  endtask

  // Drives one frame from the cycle after a posedge; p1/p2 are stray start
  // pulses, start_in_done also raises start during the done cycle.
  task automatic run_frame(input bit inv, input int p1, input int p2, input bit start_in_done);
    @(posedge clk_i); #1;
    base  = cyc;
    inv_i = inv;
    push_frame(inv, 1000);
    for (int rel = 0; rel <= 110; rel++) begin
      start_i = (rel == 0) || (rel == p1) || (rel == p2) || (start_in_done && rel == 101);
      @(negedge clk_i);
      check("busy", busy_o, (rel >= 1 && rel <= 101));
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    check("queues_drained", rd_q.size() + tw_q.size() + wr_q.size() + done_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      check_quiet("idle_after_reset");
    end

    run_frame(1'b0, -1, -1, 1'b0);
    run_frame(1'b0, 5, 40, 1'b1);

    // Abort in cycle 30: reset low for cycles 30-31.
    @(posedge clk_i); #1;
    base = cyc;
    push_frame(1'b0, 30);
    for (int rel = 0; rel < 30; rel++) begin
      start_i = (rel == 0);
      @(posedge clk_i); #1;
    end
    rst_n = 1'b0;
    for (int rel = 30; rel <= 60; rel++) begin
      if (rel == 32) rst_n = 1'b1;
      @(negedge clk_i);
      check_quiet("quiet_after_abort");
      @(posedge clk_i); #1;
    end
    check("abort_queues", rd_q.size() + tw_q.size() + wr_q.size() + done_q.size(), 0);

    run_frame(1'b0, -1, -1, 1'b0);
`ifdef FFT_SEQ_INVERSE_EN
    run_frame(1'b1, -1, -1, 1'b0);
`endif

    repeat (5) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
